// File: rtl/sap_ram_prog.sv
// SAP main memory: MAR loaded from the W bus, tri-state read port, run-mode
// writes, and a handshaked sequential program-load mode that fills the array.
module sap_ram_prog #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  inout  wire logic [DATA_WIDTH-1:0] w_bus,
  input  logic                       mar_load,
  input  logic                       enable,
  input  logic                       ram_write,
  input  logic                       prog_start,
  input  logic                       prog_valid,
  input  logic [DATA_WIDTH-1:0]      prog_data,
  output logic                       prog_ready,
  output logic                       prog_busy,
  output logic                       prog_done,
  output logic                       bus_conflict
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {RUN, LOAD} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   mar;
  logic [ADDR_WIDTH-1:0]   ptr;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic                    bus_drive;

  assign bus_drive  = (state == RUN) && enable;
  assign w_bus      = bus_drive ? mem[mar] : 'z;
  assign prog_ready = (state == LOAD);
  assign prog_busy  = (state == LOAD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= RUN;
      mar          <= '0;
      ptr          <= '0;
      prog_done    <= 1'b0;
      bus_conflict <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      prog_done    <= 1'b0;
      bus_conflict <= 1'b0;
      case (state)
        RUN: begin
          // mar_load with enable reads back the memory's own bus word (indirect addressing)
          if (mar_load) mar <= w_bus[ADDR_WIDTH-1:0];
          if (ram_write && !enable) mem[mar] <= w_bus;
          bus_conflict <= ram_write && enable;
          if (prog_start) begin
            state <= LOAD;
            ptr   <= '0;
          end
        end
        LOAD: begin
          if (prog_valid) begin
            mem[ptr] <= prog_data;
            ptr      <= ptr + 1'b1;
            if (&ptr) begin
              state     <= RUN;
              prog_done <= 1'b1;
            end
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_sap_ram_prog.sv
// Scoreboard bench for sap_ram_prog: stimulus queues expected observations,
// a negedge monitor pops and compares them. Pulled-up buses read all-ones when idle.
module tb_sap_ram_prog;

  localparam int K_BUS    = 0;
  localparam int K_BUSY   = 1;
  localparam int K_READY  = 2;
  localparam int K_DONE   = 3;
  localparam int K_CONF   = 4;
  localparam int K_BUS16  = 5;
  localparam int K_BUSY16 = 6;
  localparam int K_DONE16 = 7;
  localparam int K_DCNT   = 8;
  localparam logic [15:0] Z8  = 16'h00FF;
  localparam logic [15:0] Z16 = 16'hFFFF;

  typedef struct {
    int          kind;
    logic [15:0] exp;
    string       nm;
  } item_t;

  item_t sb[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    done_cnt = 0;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // 8-bit instance
  tri1  [7:0] w_bus;
  logic [7:0] tb_drv = '0;
  logic       tb_oe = 1'b0;
  logic       mar_load = 1'b0, enable = 1'b0, ram_write = 1'b0;
  logic       prog_start = 1'b0, prog_valid = 1'b0;
  logic [7:0] prog_data = '0;
  logic       prog_ready, prog_busy, prog_done, bus_conflict;
  assign w_bus = tb_oe ? tb_drv : 'z;

  sap_ram_prog #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .w_bus(w_bus), .mar_load(mar_load),
    .enable(enable), .ram_write(ram_write), .prog_start(prog_start),
    .prog_valid(prog_valid), .prog_data(prog_data), .prog_ready(prog_ready),
    .prog_busy(prog_busy), .prog_done(prog_done), .bus_conflict(bus_conflict)
  );

  // 16-bit / 64-word instance
  tri1  [15:0] w_bus16;
  logic [15:0] drv16 = '0;
  logic        oe16 = 1'b0;
  logic        mar16 = 1'b0, en16 = 1'b0, wr16 = 1'b0;
  logic        start16 = 1'b0, valid16 = 1'b0;
  logic [15:0] data16 = '0;
  logic        ready16, busy16, done16, conf16;
  assign w_bus16 = oe16 ? drv16 : 'z;

  sap_ram_prog #(.DATA_WIDTH(16), .ADDR_WIDTH(6)) dut16 (
    .clk(clk), .reset(reset), .w_bus(w_bus16), .mar_load(mar16),
    .enable(en16), .ram_write(wr16), .prog_start(start16),
    .prog_valid(valid16), .prog_data(data16), .prog_ready(ready16),
    .prog_busy(busy16), .prog_done(done16), .bus_conflict(conf16)
  );

  task automatic push(input int kind, input logic [15:0] e, input string nm);
    item_t it;
    it.kind = kind;
    it.exp  = e;
    it.nm   = nm;
    sb.push_back(it);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic read8(input logic [3:0] a, input logic [7:0] e, input string tag);
    cyc(); enable = 1'b0; tb_oe = 1'b1; tb_drv = {4'h0, a}; mar_load = 1'b1;
    cyc(); tb_oe = 1'b0; mar_load = 1'b0; enable = 1'b1;
    push(K_BUS, {8'h00, e}, $sformatf("%s_rd%0h", tag, a));
    cyc(); enable = 1'b0;
  endtask

  task automatic read16(input logic [5:0] a, input logic [15:0] e);
    cyc(); oe16 = 1'b1; drv16 = {10'h0, a}; mar16 = 1'b1;
    cyc(); oe16 = 1'b0; mar16 = 1'b0; en16 = 1'b1;
    push(K_BUS16, e, $sformatf("rd16_%0d", a));
    cyc(); en16 = 1'b0;
  endtask

  // Monitor
  always @(negedge clk) begin
    item_t       it;
    logic [15:0] act;
    if (prog_done === 1'b1) done_cnt++;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      case (it.kind)
        K_BUS:    act = {8'h00, w_bus};
        K_BUSY:   act = {15'h0, prog_busy};
        K_READY:  act = {15'h0, prog_ready};
        K_DONE:   act = {15'h0, prog_done};
        K_CONF:   act = {15'h0, bus_conflict};
        K_BUS16:  act = w_bus16;
        K_BUSY16: act = {15'h0, busy16};
        K_DONE16: act = {15'h0, done16};
        default:  act = 16'(done_cnt);
      endcase
      vectors++;
      if (act !== it.exp) begin
        miscompares++;
        $display("FAIL %s: got %h expected %h", it.nm, act, it.exp);
      end
    end
  end

  initial begin
    // Asynchronous reset asserted mid-cycle
    @(posedge clk); #3; reset = 1'b1;
    push(K_BUS, Z8, "rst_bus_z");
    push(K_BUSY, 16'h0, "rst_busy");
    push(K_READY, 16'h0, "rst_ready");
    push(K_DONE, 16'h0, "rst_done");
    push(K_CONF, 16'h0, "rst_conf");
    cyc(); reset = 1'b0;
    cyc(); enable = 1'b1; push(K_BUS, 16'h0000, "rst_mem0");
    cyc(); enable = 1'b0;

    // Full program load 0x10..0x1F
    cyc(); prog_start = 1'b1; push(K_BUSY, 16'h0, "start_cycle_busy");
    for (int i = 0; i < 16; i++) begin
      cyc(); prog_start = 1'b0; prog_valid = 1'b1; prog_data = 8'(8'h10 + i);
      push(K_READY, 16'h1, $sformatf("load_ready%0d", i));
      push(K_BUSY, 16'h1, $sformatf("load_busy%0d", i));
      push(K_DONE, 16'h0, $sformatf("load_nodone%0d", i));
    end
    cyc(); prog_valid = 1'b0;
    push(K_DONE, 16'h1, "load_done");
    push(K_BUSY, 16'h0, "load_busy_end");
    push(K_READY, 16'h0, "load_ready_end");
    cyc(); push(K_DONE, 16'h0, "load_done_once");
    for (int a = 0; a < 16; a++) read8(4'(a), 8'(8'h10 + a), "l1");

    // Conflict at MAR=3 holding 0x13
    cyc(); tb_oe = 1'b1; tb_drv = 8'h03; mar_load = 1'b1;
    cyc(); tb_oe = 1'b0; mar_load = 1'b0; enable = 1'b1; ram_write = 1'b1;
    push(K_BUS, 16'h0013, "conf_bus"); push(K_CONF, 16'h0, "conf_pre");
    cyc(); ram_write = 1'b0;
    push(K_CONF, 16'h1, "conf_pulse"); push(K_BUS, 16'h0013, "conf_mem3");
    cyc(); enable = 1'b0;
    push(K_CONF, 16'h0, "conf_once"); push(K_BUS, Z8, "conf_bus_z");

    // Load with stall and isolation, words 0x20..0x2F, MAR stays 3
    cyc(); prog_start = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 5) begin
        cyc(); prog_valid = 1'b0; enable = 1'b1;
        push(K_BUS, Z8, "stall_bus_z0"); push(K_READY, 16'h1, "stall_ready");
        cyc(); enable = 1'b0; tb_oe = 1'b1; tb_drv = 8'h02;
        mar_load = 1'b1; ram_write = 1'b1; prog_start = 1'b1;
        cyc(); tb_oe = 1'b0; ram_write = 1'b0; prog_start = 1'b0; enable = 1'b1;
        push(K_BUS, Z8, "stall_bus_z2"); push(K_BUSY, 16'h1, "stall_busy");
      end
      cyc(); prog_start = 1'b0; enable = 1'b0; mar_load = 1'b0;
      prog_valid = 1'b1; prog_data = 8'(8'h20 + i);
    end
    cyc(); prog_valid = 1'b0;
    push(K_DONE, 16'h1, "stall_done"); push(K_BUSY, 16'h0, "stall_busy_end");
    cyc(); enable = 1'b1; push(K_BUS, 16'h0023, "mar_preserved");
    cyc(); enable = 1'b0;
    for (int a = 0; a < 16; a++) read8(4'(a), 8'(8'h20 + a), "l2");

    // Run-mode write/read-back at 0x7, then indirect MAR load
    cyc(); tb_oe = 1'b1; tb_drv = 8'h07; mar_load = 1'b1;
    cyc(); tb_drv = 8'hA5; mar_load = 1'b0; ram_write = 1'b1;
    cyc(); tb_oe = 1'b0; ram_write = 1'b0; enable = 1'b1;
    push(K_BUS, 16'h00A5, "wr7_read");
    cyc(); enable = 1'b0; push(K_BUS, Z8, "wr7_bus_z");
    cyc(); enable = 1'b1; mar_load = 1'b1; push(K_BUS, 16'h00A5, "indir_src");
    cyc(); mar_load = 1'b0; push(K_BUS, 16'h0025, "indir_dst");
    cyc(); enable = 1'b0;

    // Reset after 5 words of a load
    cyc(); prog_start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(); prog_start = 1'b0; prog_valid = 1'b1; prog_data = 8'(8'h40 + i);
    end
    @(posedge clk); #3; reset = 1'b1; prog_valid = 1'b0;
    push(K_BUSY, 16'h0, "midrst_busy"); push(K_READY, 16'h0, "midrst_ready");
    cyc(); reset = 1'b0; push(K_DONE, 16'h0, "midrst_nodone");
    for (int a = 0; a < 16; a++) read8(4'(a), 8'h00, "clr");
    cyc(); push(K_DCNT, 16'd2, "done_pulse_count");

    // 64-word load on the wide instance
    cyc(); start16 = 1'b1;
    for (int i = 0; i < 64; i++) begin
      cyc(); start16 = 1'b0; valid16 = 1'b1; data16 = 16'(16'h1000 + i);
      if (i == 0 || i == 63) push(K_BUSY16, 16'h1, $sformatf("w_busy%0d", i));
      push(K_DONE16, 16'h0, $sformatf("w_nodone%0d", i));
    end
    cyc(); valid16 = 1'b0;
    push(K_DONE16, 16'h1, "w_done"); push(K_BUSY16, 16'h0, "w_busy_end");
    cyc(); push(K_DONE16, 16'h0, "w_done_once");
    read16(6'd0, 16'h1000);
    read16(6'd40, 16'h1028);
    read16(6'd63, 16'h103F);

    cyc(); cyc();
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
